// File: rtl/mux4_arbiter_if.sv
// Bundle of the four requester channels and the single downstream channel
// that surround the round-robin mux arbiter.
interface mux4_arbiter_if #(
  parameter int Width = 8
);

  logic [3:0]       req_i;
  logic [3:0]       lock_i;
  logic [Width-1:0] data0_i;
  logic [Width-1:0] data1_i;
  logic [Width-1:0] data2_i;
  logic [Width-1:0] data3_i;
  logic [3:0]       gnt_o;
  logic [1:0]       sel_o;
  logic             valid_o;
  logic [Width-1:0] data_o;
  logic             ready_i;

  // Producer/consumer side: drives requests, data and ready; observes grants and output beat.
  modport master (
    output req_i, lock_i, data0_i, data1_i, data2_i, data3_i, ready_i,
    input  gnt_o, sel_o, valid_o, data_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, lock_i, data0_i, data1_i, data2_i, data3_i, ready_i,
    output gnt_o, sel_o, valid_o, data_o
  );

endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a 4:1 data mux with per-requester burst lock and a
// registered valid/ready output slot. Grants are combinational from the
// request vector and slot state; the output beat is registered.
module mux4_arbiter #(
  parameter int Width = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  mux4_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       r_ptr;
  logic [1:0]       r_owner;
  logic             r_valid;
  logic [Width-1:0] r_data;
  logic [1:0]       r_sel;

  logic             w_slotFree;
  logic             w_found;
  logic [1:0]       w_winner;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic [3:0]       w_gnt;
  logic [Width-1:0] w_muxData;

  assign w_slotFree = !r_valid || bus.ready_i;

  // Rotating-priority scan: first requester after the last-granted one, with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && bus.req_i[r_ptr + 2'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 2'(i);
      end
    end
  end

  // Next-state and grant: in LOCKED only the owner may be granted, others wait.
  always_comb begin
    w_stateNext = r_state;
    w_grant     = w_winner;
    w_accept    = 1'b0;
    w_gnt       = 4'b0000;
    if (rst_ni && w_slotFree) begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            w_accept = 1'b1;
            w_grant  = w_winner;
            if (bus.lock_i[w_winner]) begin
              w_stateNext = LOCKED;
            end
          end
        end
        LOCKED: begin
          w_grant = r_owner;
          if (bus.req_i[r_owner]) begin
            w_accept = 1'b1;
            if (!bus.lock_i[r_owner]) begin
              w_stateNext = IDLE;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
    if (w_accept) begin
      w_gnt = 4'b0001 << w_grant;
    end
  end

  // Data path select for the granted requester.
  always_comb begin
    w_muxData = bus.data0_i;
    case (w_grant)
      2'd0: w_muxData = bus.data0_i;
      2'd1: w_muxData = bus.data1_i;
      2'd2: w_muxData = bus.data2_i;
      2'd3: w_muxData = bus.data3_i;
      default: w_muxData = bus.data0_i;
    endcase
  end

  // Arbitration state: the pointer and owner only move when a beat is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= 2'd3;
      r_owner <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_ptr   <= w_grant;
        r_owner <= w_grant;
      end
    end
  end

  // Output slot: a new beat replaces the old one; otherwise a consumed beat empties the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_muxData;
      r_sel   <= w_grant;
    end else if (r_valid && bus.ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.gnt_o   = w_gnt;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.sel_o   = r_sel;

endmodule
